// File: rtl/mem_pkg.sv
// Shared BRAM constants and helpers for the memory-port blocks.
package mem_pkg;

    localparam int BRAM_LATENCY_HP = 2;
    localparam int BRAM_LATENCY_LL = 1;
    localparam int NB_COL_DEF      = 4;
    localparam int COL_WIDTH_DEF   = 8;
    localparam int DATA_WIDTH_DEF  = NB_COL_DEF * COL_WIDTH_DEF;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// Response FIFO of {we, rdata} entries; any depth >= 1, pointers wrap by compare-and-clear.
// While empty the output holds the last popped entry so the response bus stays stable.
module bram_rsp_fifo
    import mem_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH_DEF + 1,
    parameter int DEPTH = 4,
    parameter int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);
    localparam int               PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_last;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~w_full | w_pop);
    assign o_count = r_count;
    assign o_data  = o_empty ? r_last : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + PTR_W'(1);
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bram_port_controller.sv
// Single-port initiator for a byte-write read-first BRAM: request stream in, one response per
// accepted request out, credit-limited so every issued read has a guaranteed FIFO slot.
module bram_port_controller
    import mem_pkg::*;
#(
    parameter int NB_COL     = NB_COL_DEF,
    parameter int COL_WIDTH  = COL_WIDTH_DEF,
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = BRAM_LATENCY_HP,
    parameter int RSP_DEPTH  = 4,
    localparam int DATA_WIDTH = NB_COL * COL_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [NB_COL-1:0]     req_wstrb,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_we,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  bram_en,
    output logic [NB_COL-1:0]     bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic                  bram_regce,
    output logic                  bram_rst,
    input  logic [DATA_WIDTH-1:0] bram_dout
);
    localparam int CNT_W = clog2(RSP_DEPTH + 1);

    logic                  w_accept;
    logic                  w_pop;
    logic                  w_empty;
    logic [LATENCY-1:0]    r_vld_pipe;
    logic [LATENCY-1:0]    r_we_pipe;
    logic [CNT_W-1:0]      w_inflight;
    logic [CNT_W-1:0]      w_fifo_count;
    logic [CNT_W:0]        w_used;
    logic [DATA_WIDTH:0]   w_rsp_data;

    assign w_accept   = req_valid & req_ready;
    assign bram_en    = w_accept;
    assign bram_we    = {NB_COL{w_accept & req_we}} & req_wstrb;
    assign bram_addr  = req_addr;
    assign bram_din   = req_wdata;
    assign bram_regce = 1'b1;
    assign bram_rst   = 1'b0;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LATENCY; i++) w_inflight = w_inflight + CNT_W'(r_vld_pipe[i]);
    end

    // Both terms are registered, so a pop only frees its credit on the following cycle.
    assign w_used    = {1'b0, w_inflight} + {1'b0, w_fifo_count};
    assign req_ready = ~rst_in & (w_used < (CNT_W + 1)'(RSP_DEPTH));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_vld_pipe <= '0;
            r_we_pipe  <= '0;
        end else begin
            r_vld_pipe[0] <= w_accept;
            r_we_pipe[0]  <= req_we;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_we_pipe[i]  <= r_we_pipe[i-1];
            end
        end
    end

    // Last stage lines up with the cycle the BRAM presents douta for that request.
    bram_rsp_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (RSP_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .i_clk       (clk_in),
        .i_rst       (rst_in),
        .i_push      (r_vld_pipe[LATENCY-1]),
        .i_push_data ({r_we_pipe[LATENCY-1], bram_dout}),
        .i_pop       (w_pop),
        .o_data      (w_rsp_data),
        .o_empty     (w_empty),
        .o_count     (w_fifo_count)
    );

    assign rsp_valid = ~w_empty;
    assign w_pop     = rsp_valid & rsp_ready;
    assign rsp_we    = w_rsp_data[DATA_WIDTH];
    assign rsp_rdata = w_rsp_data[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_bram_port_controller.sv
// Scoreboard bench: a high-performance (LATENCY=2) and a low-latency (LATENCY=1) build, each on its own BRAM model.
module tb_bram_port_controller;

    typedef struct packed { logic we; logic [31:0] d; } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_in, req_valid, req_we, rsp_ready;
    logic [3:0]  req_wstrb;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    bit   sel;
    logic vld_hp, vld_ll;
    assign vld_hp = req_valid & ~sel;
    assign vld_ll = req_valid & sel;

    logic        rdy_hp, rsp_valid_hp, rsp_we_hp, en_hp, regce_hp, brst_hp;
    logic [3:0]  we_hp;
    logic [9:0]  addr_hp;
    logic [31:0] din_hp, rdata_hp;
    logic [31:0] dout_hp = '0;
    logic [31:0] q1_hp = '0;
    logic        rdy_ll, rsp_valid_ll, rsp_we_ll, en_ll, regce_ll, brst_ll;
    logic [3:0]  we_ll;
    logic [9:0]  addr_ll;
    logic [31:0] din_ll, rdata_ll;
    logic [31:0] dout_ll = '0;

    bit [31:0] mem_hp [1024];
    bit [31:0] mem_ll [1024];

    bram_port_controller #(.LATENCY(2), .RSP_DEPTH(4)) dut_hp (
        .clk_in(clk), .rst_in(rst_in), .req_valid(vld_hp), .req_ready(rdy_hp), .req_we(req_we),
        .req_wstrb(req_wstrb), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_hp),
        .rsp_ready(rsp_ready), .rsp_we(rsp_we_hp), .rsp_rdata(rdata_hp), .bram_en(en_hp), .bram_we(we_hp),
        .bram_addr(addr_hp), .bram_din(din_hp), .bram_regce(regce_hp), .bram_rst(brst_hp), .bram_dout(dout_hp));

    bram_port_controller #(.LATENCY(1), .RSP_DEPTH(3)) dut_ll (
        .clk_in(clk), .rst_in(rst_in), .req_valid(vld_ll), .req_ready(rdy_ll), .req_we(req_we),
        .req_wstrb(req_wstrb), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_ll),
        .rsp_ready(rsp_ready), .rsp_we(rsp_we_ll), .rsp_rdata(rdata_ll), .bram_en(en_ll), .bram_we(we_ll),
        .bram_addr(addr_ll), .bram_din(din_ll), .bram_regce(regce_ll), .bram_rst(brst_ll), .bram_dout(dout_ll));

    // Read-first byte-write BRAM, HIGH_PERFORMANCE (output register) and LOW_LATENCY flavours.
    always @(posedge clk) begin
        if (en_hp) begin
            q1_hp <= mem_hp[addr_hp];
            for (int b = 0; b < 4; b++) if (we_hp[b]) mem_hp[addr_hp][8*b +: 8] <= din_hp[8*b +: 8];
        end
        if (regce_hp) dout_hp <= q1_hp;
    end

    always @(posedge clk) begin
        if (en_ll) begin
            dout_ll <= mem_ll[addr_ll];
            for (int b = 0; b < 4; b++) if (we_ll[b]) mem_ll[addr_ll][8*b +: 8] <= din_ll[8*b +: 8];
        end
    end

    rsp_t q_hp[$];
    rsp_t q_ll[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   lat_t0 = 0, lat_id = 0, lat_seen = 0, lat_meas = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic cur_ready();
        return sel ? rdy_ll : rdy_hp;
    endfunction

    function automatic logic [31:0] cur_bram();
        return sel ? {17'd0, en_ll, we_ll, addr_ll} : {17'd0, en_hp, we_hp, addr_hp};
    endfunction

    // Expected word after the directed writes of each phase.
    function automatic logic [31:0] exp_data(input bit s, input int a);
        if (a == 0) return s ? 32'h11111111 : 32'hAAEECCFF;
        if (a == 1) return 32'h22222222;
        return 32'hC0DE0000 + 32'(a);
    endfunction

    task automatic push_exp(input logic we, input logic [31:0] d);
        rsp_t e;
        e.we = we;
        e.d  = d;
        if (sel) q_ll.push_back(e); else q_hp.push_back(e);
    endtask

    task automatic issue(input logic we, input logic [3:0] strb, input logic [9:0] a,
                         input logic [31:0] d, input logic [31:0] exp_d, input bit mark);
        int n;
        req_valid = 1'b1; req_we = we; req_wstrb = strb; req_addr = a; req_wdata = d;
        n = 0;
        @(negedge clk);
        while (!cur_ready() && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_tests++; n_fail++;
            $display("FAIL issue_timeout: req_ready stayed %b, expected 1", cur_ready());
        end else begin
            chk("bram_issue", cur_bram(), {17'd0, 1'b1, (we ? strb : 4'h0), a});
            push_exp(we, exp_d);
            if (mark) begin lat_t0 = cyc; lat_id++; end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_hp.size() != 0 || q_ll.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", q_hp.size() + q_ll.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic monitor();
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!rst_in) begin
                if (rsp_valid_hp && rsp_ready) begin
                    if (q_hp.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL hp_unexpected_rsp: got rdata %h, expected no response", rdata_hp);
                    end else begin
                        e = q_hp.pop_front();
                        chk("hp_rsp_we", {31'd0, rsp_we_hp}, {31'd0, e.we});
                        chk("hp_rsp_rdata", rdata_hp, e.d);
                    end
                end
                if (rsp_valid_ll && rsp_ready) begin
                    if (q_ll.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL ll_unexpected_rsp: got rdata %h, expected no response", rdata_ll);
                    end else begin
                        e = q_ll.pop_front();
                        chk("ll_rsp_we", {31'd0, rsp_we_ll}, {31'd0, e.we});
                        chk("ll_rsp_rdata", rdata_ll, e.d);
                    end
                end
                if (lat_id != lat_seen && (sel ? rsp_valid_ll : rsp_valid_hp)) begin
                    lat_meas = cyc - lat_t0;
                    lat_seen = lat_id;
                end
                chk("hp_fifo_overflow", {31'd0, dut_hp.u_fifo.w_full & dut_hp.u_fifo.i_push}, 32'd0);
                chk("ll_fifo_overflow", {31'd0, dut_ll.u_fifo.w_full & dut_ll.u_fifo.i_push}, 32'd0);
            end
        end
    endtask

    task automatic prefill();
        for (int a = 2; a < 32; a++) issue(1'b1, 4'hF, 10'(a), 32'hC0DE0000 + 32'(a), 32'h0, 1'b0);
        drain();
    endtask

    task automatic scen_basic(input int exp_lat);
        rsp_ready = 1'b1;
        issue(1'b1, 4'hF, 10'd0, 32'h11111111, 32'h0, 1'b1);
        issue(1'b1, 4'hF, 10'd1, 32'h22222222, 32'h0, 1'b0);
        issue(1'b0, 4'h0, 10'd0, 32'h0, 32'h11111111, 1'b0);
        issue(1'b0, 4'h0, 10'd1, 32'h0, 32'h22222222, 1'b0);
        drain();
        chk("first_rsp_latency", 32'(lat_meas), 32'(exp_lat));
        @(negedge clk);
        chk("empty_rsp_valid", {31'd0, sel ? rsp_valid_ll : rsp_valid_hp}, 32'd0);
        chk("empty_rdata_hold", sel ? rdata_ll : rdata_hp, 32'h22222222);
        @(posedge clk); #1;
    endtask

    task automatic scen_stream();
        int k, drops;
        rsp_ready = 1'b1; req_we = 1'b0; req_wstrb = 4'h0; req_addr = 10'd0; req_valid = 1'b1;
        k = 0; drops = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (cur_ready()) begin
                push_exp(1'b0, exp_data(sel, k));
                k++;
            end else drops++;
            @(posedge clk); #1;
            req_addr = 10'(k);
        end
        req_valid = 1'b0;
        chk("stream_accepts", 32'(k), 32'd32);
        chk("stream_ready_drops", 32'(drops), 32'd0);
        drain();
    endtask

    initial begin
        int nacc, pcyc, rcyc;
        bit acc;
        rst_in = 1'b1; sel = 1'b0; rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_wstrb = 4'hF; req_addr = 10'd5; req_wdata = 32'hDEADBEEF;
        fork monitor(); join_none

        // Reset state, with a request pending that must not reach the BRAM.
        repeat (3) @(negedge clk);
        chk("rst_req_ready_hp", {31'd0, rdy_hp}, 32'd0);
        chk("rst_req_ready_ll", {31'd0, rdy_ll}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid_hp, rsp_valid_ll}, 32'd0);
        chk("rst_rsp_we", {30'd0, rsp_we_hp, rsp_we_ll}, 32'd0);
        chk("rst_rdata_hp", rdata_hp, 32'd0);
        chk("rst_bram_en", {31'd0, en_hp}, 32'd0);
        chk("rst_bram_we", {28'd0, we_hp}, 32'd0);
        chk("tie_regce_rst", {28'd0, regce_hp, brst_hp, regce_ll, brst_ll}, 32'b1010);
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_in = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {30'd0, rdy_hp, rdy_ll}, 32'b11);
        @(posedge clk); #1;

        // High-performance build.
        scen_basic(3);
        issue(1'b1, 4'hF, 10'd0, 32'hAABBCCDD, 32'h11111111, 1'b0);
        issue(1'b0, 4'h0, 10'd0, 32'h0, 32'hAABBCCDD, 1'b0);
        issue(1'b1, 4'b0101, 10'd0, 32'h00EE00FF, 32'hAABBCCDD, 1'b0);
        issue(1'b0, 4'h0, 10'd0, 32'h0, 32'hAAEECCFF, 1'b0);
        drain();
        prefill();

        // Backpressure: credits stop acceptance at RSP_DEPTH.
        rsp_ready = 1'b0; req_we = 1'b0; req_wstrb = 4'h0; req_addr = 10'd2; req_valid = 1'b1;
        nacc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            acc = cur_ready();
            if (acc) begin push_exp(1'b0, exp_data(sel, int'(req_addr))); nacc++; end
            @(posedge clk); #1;
            if (acc) req_addr = req_addr + 10'd1;
        end
        @(negedge clk);
        chk("bp_accepts", 32'(nacc), 32'd4);
        chk("bp_ready_low", {31'd0, rdy_hp}, 32'd0);
        chk("bp_rsp_valid", {31'd0, rsp_valid_hp}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; rsp_ready = 1'b1;
        pcyc = -1; rcyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pcyc < 0 && rsp_valid_hp) pcyc = cyc;
            if (rcyc < 0 && rdy_hp) rcyc = cyc;
        end
        chk("bp_ready_after_pop", 32'(rcyc - pcyc), 32'd1);
        drain();

        scen_stream();

        // Reset with one buffered write ack and two reads in flight.
        rsp_ready = 1'b0;
        issue(1'b1, 4'hF, 10'd7, 32'h77777777, 32'hC0DE0007, 1'b0);
        issue(1'b0, 4'h0, 10'd3, 32'h0, 32'hC0DE0003, 1'b0);
        issue(1'b0, 4'h0, 10'd4, 32'h0, 32'hC0DE0004, 1'b0);
        chk("pre_rst_buffered", {31'd0, rsp_valid_hp}, 32'd1);
        #2;
        rst_in = 1'b1;
        q_hp.delete();
        #1;
        chk("rst_async_rsp_valid", {31'd0, rsp_valid_hp}, 32'd0);
        chk("rst_async_ready", {31'd0, rdy_hp}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_in = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", {31'd0, rsp_valid_hp}, 32'd0);
        end
        @(posedge clk); #1;
        issue(1'b0, 4'h0, 10'd7, 32'h0, 32'h77777777, 1'b0);
        drain();

        // Low-latency build.
        sel = 1'b1;
        scen_basic(2);
        prefill();
        scen_stream();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
